// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: collects coins, vends against a price, then pays change back in units of 5.
// Optional idle auto-refund in COLLECT is built when CREDIT_TIMEOUT_EN is defined.
module coin_credit_accumulator #(
    parameter logic [7:0] MAX_CREDIT     = 8'd200,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select,
    input  logic [7:0] price,
    input  logic       cancel,
    input  logic       change_ack,
    output logic       coin_ready,
    output logic       coin_reject,
    output logic [7:0] credit_out,
    output logic       vend,
    output logic       insufficient,
    output logic       change_req,
    output logic [7:0] change_value
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] val;
        case (code)
            2'b00:   val = 8'd5;
            2'b01:   val = 8'd10;
            2'b10:   val = 8'd25;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    function automatic logic [7:0] min_unit(input logic [7:0] credit);
        logic [7:0] unit;
        if (credit < 8'd5) begin
            unit = credit;
        end else begin
            unit = 8'd5;
        end
        return unit;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic       coin_ready_q, coin_ready_d;
    logic       coin_reject_q, coin_reject_d;
    logic       vend_q, vend_d;
    logic       insufficient_q, insufficient_d;
    logic       change_req_q, change_req_d;
    logic [7:0] change_value_q, change_value_d;

    logic       coin_ok_s;
    logic [7:0] coin_val_s;
    logic [8:0] sum_s;
    logic [7:0] refund_left_s;
    logic       timeout_s;

    assign coin_ok_s     = (coin_type != 2'b11);
    assign coin_val_s    = coin_value(coin_type);
    // 9-bit sum so a coin near the ceiling cannot wrap past it
    assign sum_s         = {1'b0, credit_q} + {1'b0, coin_val_s};
    assign refund_left_s = credit_q - change_value_q;

`ifdef CREDIT_TIMEOUT_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;

    assign timeout_s = (state_q == S_COLLECT) && (idle_cnt_q == TIMEOUT_CYCLES);

    // Idle counter restarts outside COLLECT, on a credited coin, or on an insufficient select
    always_comb begin
        idle_cnt_d = idle_cnt_q + 8'd1;
        if ((state_q != S_COLLECT) || insufficient_d || (credit_d != credit_q)) begin
            idle_cnt_d = 8'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt_q <= 8'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, credit and strobe decode
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (coin_valid && coin_ok_s) begin
                    credit_d = coin_val_s;
                    state_d  = S_COLLECT;
                end else begin
                    coin_reject_d = coin_valid;
                end
            end
            S_COLLECT: begin
                if (cancel || timeout_s) begin
                    coin_reject_d = coin_valid;
                    state_d       = S_REFUND;
                end else if (select) begin
                    coin_reject_d = coin_valid;
                    if (credit_q >= price) begin
                        credit_d = credit_q - price;
                        state_d  = S_VEND;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok_s && (sum_s <= {1'b0, MAX_CREDIT})) begin
                        credit_d = sum_s[7:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                if (credit_q != 8'd0) begin
                    state_d = S_REFUND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REFUND: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    credit_d = refund_left_s;
                    if (refund_left_s == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REFUND;
                    end
                end else begin
                    state_d = S_REFUND;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = 8'd0;
            end
        endcase
    end

    // Outputs are a function of the state being entered, so they appear with it
    always_comb begin
        vend_d         = (state_d == S_VEND);
        change_req_d   = (state_d == S_REFUND);
        coin_ready_d   = (state_d == S_IDLE) || (state_d == S_COLLECT);
        change_value_d = 8'd0;
        if (state_d == S_REFUND) begin
            change_value_d = min_unit(credit_d);
        end else begin
            change_value_d = 8'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 8'd0;
            coin_ready_q   <= 1'b1;
            coin_reject_q  <= 1'b0;
            vend_q         <= 1'b0;
            insufficient_q <= 1'b0;
            change_req_q   <= 1'b0;
            change_value_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            coin_ready_q   <= coin_ready_d;
            coin_reject_q  <= coin_reject_d;
            vend_q         <= vend_d;
            insufficient_q <= insufficient_d;
            change_req_q   <= change_req_d;
            change_value_q <= change_value_d;
        end
    end

    assign coin_ready   = coin_ready_q;
    assign coin_reject  = coin_reject_q;
    assign credit_out   = credit_q;
    assign vend         = vend_q;
    assign insufficient = insufficient_q;
    assign change_req   = change_req_q;
    assign change_value = change_value_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator; expected values are worked out by hand per vector.
module tb_coin_credit_accumulator;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       select;
    logic [7:0] price;
    logic       cancel;
    logic       change_ack;
    logic       coin_ready;
    logic       coin_reject;
    logic [7:0] credit_out;
    logic       vend;
    logic       insufficient;
    logic       change_req;
    logic [7:0] change_value;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] C5  = 2'b00;
    localparam logic [1:0] C10 = 2'b01;
    localparam logic [1:0] C25 = 2'b10;
    localparam logic [1:0] CX  = 2'b11;

    coin_credit_accumulator #(
        .MAX_CREDIT     (8'd200),
        .TIMEOUT_CYCLES (8'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .select       (select),
        .price        (price),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .coin_ready   (coin_ready),
        .coin_reject  (coin_reject),
        .credit_out   (credit_out),
        .vend         (vend),
        .insufficient (insufficient),
        .change_req   (change_req),
        .change_value (change_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        coin_valid = 1'b0;
        coin_type  = C5;
        select     = 1'b0;
        price      = 8'd0;
        cancel     = 1'b0;
        change_ack = 1'b0;
    endtask

    // Apply current inputs for one rising edge, then settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        idle_in();
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_in();
        // Reset held for two edges with a coin offered
        coin_valid = 1'b1;
        coin_type  = C25;
        step();
        step();
        chk("rst_credit", credit_out, 16'd0);
        chk("rst_ready", coin_ready, 16'd1);
        chk("rst_vend", vend, 16'd0);
        chk("rst_reject", coin_reject, 16'd0);
        chk("rst_insuf", insufficient, 16'd0);
        chk("rst_creq", change_req, 16'd0);
        chk("rst_cval", change_value, 16'd0);
        reset = 1'b1;
        idle_in();
        step();
        chk("post_rst_credit", credit_out, 16'd0);

        // Invalid coin and select in IDLE
        coin(CX);
        chk("idle_bad_reject", coin_reject, 16'd1);
        chk("idle_bad_credit", credit_out, 16'd0);
        select = 1'b1;
        price  = 8'd0;
        step();
        idle_in();
        chk("idle_sel_vend", vend, 16'd0);
        chk("idle_sel_reject", coin_reject, 16'd0);

        // Exact-price purchase
        coin(C25);
        chk("ex_c1", credit_out, 16'd25);
        coin(C10);
        chk("ex_c2", credit_out, 16'd35);
        coin(C10);
        chk("ex_c3", credit_out, 16'd45);
        select = 1'b1;
        price  = 8'd45;
        step();
        idle_in();
        chk("ex_vend", vend, 16'd1);
        chk("ex_vend_credit", credit_out, 16'd0);
        chk("ex_vend_ready", coin_ready, 16'd0);
        step();
        chk("ex_vend_off", vend, 16'd0);
        chk("ex_no_creq", change_req, 16'd0);
        chk("ex_idle_ready", coin_ready, 16'd1);

        // Purchase with change
        coin(C25);
        coin(C25);
        chk("chg_credit50", credit_out, 16'd50);
        select = 1'b1;
        price  = 8'd35;
        step();
        idle_in();
        chk("chg_vend", vend, 16'd1);
        chk("chg_vend_credit", credit_out, 16'd15);
        coin_valid = 1'b1;
        coin_type  = C10;
        step();
        idle_in();
        chk("chg_vend_off", vend, 16'd0);
        chk("chg_creq", change_req, 16'd1);
        chk("chg_cval", change_value, 16'd5);
        chk("chg_credit15", credit_out, 16'd15);
        chk("chg_vend_coin_rej", coin_reject, 16'd1);
        change_ack = 1'b1;
        step();
        chk("chg_ack1", credit_out, 16'd10);
        chk("chg_ack1_creq", change_req, 16'd1);
        step();
        chk("chg_ack2", credit_out, 16'd5);
        step();
        chk("chg_ack3", credit_out, 16'd0);
        chk("chg_ack3_creq", change_req, 16'd0);
        chk("chg_ack3_ready", coin_ready, 16'd1);
        idle_in();
        step();
        chk("chg_idle_creq", change_req, 16'd0);

        // Ceiling: 195 then a rejected 10 and an accepted 5
        for (int i = 0; i < 7; i++) coin(C25);
        coin(C10);
        coin(C10);
        chk("max_195", credit_out, 16'd195);
        coin(C10);
        chk("max_rej", coin_reject, 16'd1);
        chk("max_rej_credit", credit_out, 16'd195);
        coin(C5);
        chk("max_200", credit_out, 16'd200);
        chk("max_200_rej", coin_reject, 16'd0);
        do_reset();

        // Coin with select, cancel, then reset mid-refund
        coin(C10);
        coin(C10);
        change_ack = 1'b1;
        step();
        idle_in();
        chk("ack_collect_ignored", credit_out, 16'd20);
        coin_valid = 1'b1;
        coin_type  = C5;
        select     = 1'b1;
        price      = 8'd30;
        step();
        idle_in();
        chk("cs_insuf", insufficient, 16'd1);
        chk("cs_reject", coin_reject, 16'd1);
        chk("cs_credit", credit_out, 16'd20);
        chk("cs_vend", vend, 16'd0);
        cancel = 1'b1;
        step();
        idle_in();
        chk("cs_insuf_off", insufficient, 16'd0);
        chk("cn_creq", change_req, 16'd1);
        chk("cn_cval", change_value, 16'd5);
        chk("cn_ready", coin_ready, 16'd0);
        change_ack = 1'b1;
        step();
        chk("cn_ack1", credit_out, 16'd15);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle_in();
        chk("rr_credit", credit_out, 16'd0);
        chk("rr_creq", change_req, 16'd0);
        chk("rr_ready", coin_ready, 16'd1);
        coin(C5);
        chk("rr_idle_coin", credit_out, 16'd5);
        do_reset();

        // Idle behaviour in COLLECT
        coin(C10);
`ifdef CREDIT_TIMEOUT_EN
        for (int i = 0; i < 4; i++) step();
        chk("to_before", change_req, 16'd0);
        step();
        chk("to_creq", change_req, 16'd1);
        chk("to_credit", credit_out, 16'd10);
`else
        for (int i = 0; i < 300; i++) step();
        chk("hold_credit", credit_out, 16'd10);
        chk("hold_creq", change_req, 16'd0);
        chk("hold_ready", coin_ready, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
- Front-end stage of the vending machine; sits directly upstream of the 8-bit display/holding register.
- Accepts coin insertions, keeps a running credit and compares it against the selected item price.
- Issues a one-cycle vend strobe, then pays change back one unit per handshake.
- Drives credit_out, which feeds the downstream register's data_in every cycle.

Parameters:
- MAX_CREDIT, 8'd200: credit ceiling. A coin that would exceed it is rejected.
- TIMEOUT_CYCLES, 8'd255: idle cycles in COLLECT before auto-refund. Used only with the optional feature.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-low. While 0 at a rising clk edge, all state clears.
- coin_valid, input, 1: coin present this cycle.
- coin_type, input, 2: coin value code. 00=5, 01=10, 10=25, 11=invalid.
- select, input, 1: purchase request.
- price, input, 8: item price, sampled when select=1. Must be a multiple of 5.
- cancel, input, 1: refund request.
- change_ack, input, 1: change dispenser accepted the current change unit.
- coin_ready, output, 1: block accepts coins. 1 in IDLE and COLLECT.
- coin_reject, output, 1: one-cycle pulse when a coin was not credited.
- credit_out, output, 8: current credit. Feeds the downstream register.
- vend, output, 1: one-cycle dispense strobe.
- insufficient, output, 1: one-cycle pulse when select arrives with credit below price.
- change_req, output, 1: change unit pending.
- change_value, output, 8: value of the pending change unit.

Behaviour:
- All outputs are registered and update one clk after the triggering input.
- Reset values: state=IDLE, credit_out=0, coin_ready=1, and every other output 0.
- Reset has priority over all other inputs in every state, including mid-REFUND. Pending change is discarded and change_req drops on the reset edge.
- IDLE:
  - Valid coin (coin_type != 11) -> credit=value, go to COLLECT.
  - Invalid coin -> coin_reject pulse, stay in IDLE.
  - select or cancel -> ignored.
- COLLECT:
  - Input priority: cancel > select > coin.
  - cancel -> go to REFUND.
  - select with credit >= price -> credit -= price, go to VEND.
  - select with credit < price -> insufficient pulse, credit unchanged.
  - Coin arriving together with cancel or select -> coin_reject pulse, coin not credited.
  - Coin alone: if credit+value <= MAX_CREDIT, add it. Otherwise coin_reject pulse and credit unchanged.
  - Addition is 9-bit internally, so credit never wraps.
- VEND:
  - vend=1 for exactly one cycle.
  - Next state: REFUND if credit > 0, else IDLE.
  - coin_ready=0 here; coins are dropped and coin_reject pulses.
- REFUND:
  - change_req=1 and change_value = min(credit, 5).
  - On a cycle with change_ack=1, credit -= change_value.
  - When credit reaches 0: change_req=0 the next cycle, go to IDLE.
  - coin_ready=0; coins are dropped with coin_reject. select and cancel are ignored.
  - change_ack outside REFUND is ignored.
- A single select with credit == price -> VEND, then IDLE with credit_out=0.

Optional Feature:
- Macro: CREDIT_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs in COLLECT.
  - It clears on entry to COLLECT, on any credited coin, and on an insufficient select.
  - When it reaches TIMEOUT_CYCLES, the block enters REFUND on the next edge, exactly as for cancel.
- Undefined:
  - No counter is built and TIMEOUT_CYCLES is unused.
  - COLLECT holds credit indefinitely.

Test Plan:
- Reset held 0 for 2 edges, then released -> credit_out=0, coin_ready=1, all strobes 0. A coin during reset is not credited.
- Coins 25, 10, 10, then select with price=45 -> credit_out 25, 35, 45. Then vend=1 for one cycle, credit_out=0, state IDLE, no change_req.
- Coins 25, 25, then select with price=35 -> vend. Then change_req=1, change_value=5, credit 15. With change_ack every cycle, credit goes 10, 5, 0: 3 acks, then IDLE.
- Credit 195, insert 10 -> coin_reject, credit stays 195. Insert 5 -> credit 200.
- In COLLECT with credit 20: coin + select (price 30) in the same cycle -> insufficient=1, coin_reject=1, credit stays 20. Then cancel, and reset asserted after 1 ack -> credit_out=0, change_req=0, state IDLE.
- With CREDIT_TIMEOUT_EN and TIMEOUT_CYCLES=4: insert 10, then idle -> change_req rises 5 cycles after the coin. Without the macro -> credit stays 10 after 300 cycles.
